// File: rtl/sd_cmd_arbiter_if.sv
// Requester/engine bundle for sd_cmd_arbiter.
//   req_*  : per-requester command request (valid/ready) and completion (rsp_*)
//   eng_*  : single shared SD command engine start/done/timeout/crc interface
// slave  : arbiter view.  master : requester + engine view (bench / surrounding logic).
interface sd_cmd_arbiter_if #(
    parameter int unsigned NUM_REQ = 3
);
    logic [NUM_REQ-1:0]    req_valid_i;
    logic [NUM_REQ-1:0]    req_app_i;
    logic [6*NUM_REQ-1:0]  req_index_i;
    logic [32*NUM_REQ-1:0] req_arg_i;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic [NUM_REQ-1:0]    rsp_valid_o;
    logic [1:0]            rsp_status_o;
    logic [39:0]           rsp_data_o;
    logic [5:0]            eng_index_o;
    logic [31:0]           eng_arg_o;
    logic                  eng_start_o;
    logic                  eng_busy_i;
    logic                  eng_done_i;
    logic [39:0]           eng_response_i;
    logic                  eng_timeout_i;
    logic                  eng_crc_error_i;

    modport slave (
        input  req_valid_i, req_app_i, req_index_i, req_arg_i,
        input  eng_busy_i, eng_done_i, eng_response_i, eng_timeout_i, eng_crc_error_i,
        output req_ready_o, rsp_valid_o, rsp_status_o, rsp_data_o,
        output eng_index_o, eng_arg_o, eng_start_o
    );

    modport master (
        output req_valid_i, req_app_i, req_index_i, req_arg_i,
        output eng_busy_i, eng_done_i, eng_response_i, eng_timeout_i, eng_crc_error_i,
        input  req_ready_o, rsp_valid_o, rsp_status_o, rsp_data_o,
        input  eng_index_o, eng_arg_o, eng_start_o
    );
endinterface

// File: rtl/sd_cmd_arbiter.sv
// Round-robin arbiter sharing one SD command engine among NUM_REQ requesters.
// Sequences each granted command onto the engine, prefixes CMD55 for ACMDs,
// retries on CRC error and returns a per-requester completion pulse.
// Ports:
//   PCLK_i, PRESETn_i : clock, asynchronous active-low reset
//   arb_enable_i      : allow new grants
//   rca_i             : card RCA, used as CMD55 argument {rca_i, 16'h0}
//   bus               : request/response and engine signals (slave modport)
//   busy_o            : arbiter owns the engine
//   grant_id_o        : current owner index
//   retry_cnt_o       : CRC retries used on the current request
module sd_cmd_arbiter #(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned RETRY_MAX   = 2,
    parameter int unsigned WDOG_CYCLES = 4096
) (
    input  logic                PCLK_i,
    input  logic                PRESETn_i,
    input  logic                arb_enable_i,
    input  logic [15:0]         rca_i,
    sd_cmd_arbiter_if.slave     bus,
    output logic                busy_o,
    output logic [2:0]          grant_id_o,
    output logic [1:0]          retry_cnt_o
);
    localparam int unsigned WdW = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [WdW-1:0] WdogLast = WdW'(WDOG_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StPre55, StMain, StWait, StGap, StReport} state_e;

    state_e        state_q, state_d;
    logic [2:0]    rr_q, rr_d;
    logic [2:0]    grant_q, grant_d;
    logic [5:0]    index_q, index_d;
    logic [31:0]   arg_q, arg_d;
    logic          app_q, app_d;
    logic          phase_main_q, phase_main_d;   // command in flight is the main one, not CMD55
    logic          next_main_q, next_main_d;     // issue state to use when leaving GAP
    logic [1:0]    retry_q, retry_d;
    logic [WdW-1:0] wdog_q, wdog_d;
    logic [1:0]    status_q, status_d;
    logic [39:0]   data_q, data_d;
    logic [5:0]    eng_index_q, eng_index_d;
    logic [31:0]   eng_arg_q, eng_arg_d;

    // Round-robin search starting at rr_q.
    logic [7:0] valid_pad;
    logic [3:0] cand;
    logic       found;
    logic [2:0] winner;
    logic       grant_fire;

    always_comb begin
        valid_pad = 8'(bus.req_valid_i);
        cand      = 4'd0;
        found     = 1'b0;
        winner    = 3'd0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_q} + 4'(i);
            if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
            if (!found && valid_pad[cand[2:0]]) begin
                found  = 1'b1;
                winner = cand[2:0];
            end
        end
    end

    assign grant_fire = (state_q == StIdle) && arb_enable_i && found;

    // Issue-state engine drive; the registered copy holds the value between issues.
    logic        issuing;
    logic [5:0]  issue_index;
    logic [31:0] issue_arg;

    assign issuing     = (state_q == StPre55) || (state_q == StMain);
    assign issue_index = (state_q == StPre55) ? 6'd55 : index_q;
    assign issue_arg   = (state_q == StPre55) ? {rca_i, 16'h0000} : arg_q;

    assign bus.eng_start_o = issuing;
    assign bus.eng_index_o = issuing ? issue_index : eng_index_q;
    assign bus.eng_arg_o   = issuing ? issue_arg : eng_arg_q;

    // Ready is combinational in IDLE; gated by reset so all outputs read 0 while held.
    always_comb begin
        bus.req_ready_o = '0;
        bus.rsp_valid_o = '0;
        if (grant_fire && PRESETn_i) begin
            bus.req_ready_o = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
        end
        if (state_q == StReport) begin
            bus.rsp_valid_o = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
        end
    end

    assign bus.rsp_status_o = status_q;
    assign bus.rsp_data_o   = data_q;
    assign busy_o           = (state_q != StIdle);
    assign grant_id_o       = grant_q;
    assign retry_cnt_o      = retry_q;

    logic [3:0] rr_nxt;

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        grant_d      = grant_q;
        index_d      = index_q;
        arg_d        = arg_q;
        app_d        = app_q;
        phase_main_d = phase_main_q;
        next_main_d  = next_main_q;
        retry_d      = retry_q;
        wdog_d       = wdog_q;
        status_d     = status_q;
        data_d       = data_q;
        eng_index_d  = eng_index_q;
        eng_arg_d    = eng_arg_q;
        rr_nxt       = {1'b0, grant_q} + 4'd1;
        if (rr_nxt >= 4'(NUM_REQ)) rr_nxt = 4'd0;

        unique case (state_q)
            StIdle: begin
                if (grant_fire) begin
                    grant_d = winner;
                    retry_d = 2'd0;
                    for (int unsigned r = 0; r < NUM_REQ; r++) begin
                        if (3'(r) == winner) begin
                            index_d = bus.req_index_i[6*r +: 6];
                            arg_d   = bus.req_arg_i[32*r +: 32];
                            app_d   = bus.req_app_i[r];
                        end
                    end
                    state_d = bus.req_app_i[winner] ? StPre55 : StMain;
                end
            end
            StPre55, StMain: begin
                eng_index_d  = issue_index;
                eng_arg_d    = issue_arg;
                phase_main_d = (state_q == StMain);
                wdog_d       = '0;
                state_d      = StWait;
            end
            StWait: begin
                wdog_d = wdog_q + 1'b1;
                if (bus.eng_timeout_i) begin
                    status_d = 2'b01;
                    state_d  = StReport;
                end else if (bus.eng_crc_error_i) begin
                    if (32'(retry_q) < RETRY_MAX) begin
                        retry_d     = retry_q + 2'd1;
                        next_main_d = !app_q;
                        state_d     = StGap;
                    end else begin
                        status_d = 2'b10;
                        state_d  = StReport;
                    end
                end else if (bus.eng_done_i) begin
                    if (!phase_main_q) begin
                        // CMD55 accepted; its response is not reported.
                        next_main_d = 1'b1;
                        state_d     = StGap;
                    end else begin
                        data_d   = bus.eng_response_i;
                        status_d = 2'b00;
                        state_d  = StReport;
                    end
                end else if (wdog_q == WdogLast) begin
                    status_d = 2'b11;
                    state_d  = StReport;
                end
            end
            StGap: begin
                if (!bus.eng_busy_i) state_d = next_main_q ? StMain : StPre55;
            end
            StReport: begin
                rr_d    = rr_nxt[2:0];
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i) begin
            state_q      <= StIdle;
            rr_q         <= 3'd0;
            grant_q      <= 3'd0;
            index_q      <= 6'd0;
            arg_q        <= 32'd0;
            app_q        <= 1'b0;
            phase_main_q <= 1'b0;
            next_main_q  <= 1'b0;
            retry_q      <= 2'd0;
            wdog_q       <= '0;
            status_q     <= 2'b00;
            data_q       <= 40'd0;
            eng_index_q  <= 6'd0;
            eng_arg_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            grant_q      <= grant_d;
            index_q      <= index_d;
            arg_q        <= arg_d;
            app_q        <= app_d;
            phase_main_q <= phase_main_d;
            next_main_q  <= next_main_d;
            retry_q      <= retry_d;
            wdog_q       <= wdog_d;
            status_q     <= status_d;
            data_q       <= data_d;
            eng_index_q  <= eng_index_d;
            eng_arg_q    <= eng_arg_d;
        end
    end
endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// Scoreboard bench for sd_cmd_arbiter: tests push expected grants, engine starts and
// responses; independent monitors pop and compare when the DUT presents them.
module tb_sd_cmd_arbiter;
    localparam int unsigned NR = 3;
    localparam int unsigned RM = 2;
    localparam int unsigned WD = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arb_en = 1'b0;
    logic [15:0] rca = 16'h0;
    logic        busy;
    logic [2:0]  gid;
    logic [1:0]  rcnt;

    sd_cmd_arbiter_if #(.NUM_REQ(NR)) bus ();

    sd_cmd_arbiter #(.NUM_REQ(NR), .RETRY_MAX(RM), .WDOG_CYCLES(WD)) dut (
        .PCLK_i       (clk),
        .PRESETn_i    (rst_n),
        .arb_enable_i (arb_en),
        .rca_i        (rca),
        .bus          (bus),
        .busy_o       (busy),
        .grant_id_o   (gid),
        .retry_cnt_o  (rcnt)
    );

    initial forever #5 clk = ~clk;

    typedef enum int {KDone, KCrc, KTo, KNone} kind_e;
    typedef struct { kind_e kind; int delay; logic [39:0] resp; } act_t;
    typedef struct { int id; logic [1:0] st; logic [39:0] data; } rsp_t;

    int          exp_grant[$];
    logic [37:0] exp_start[$];
    act_t        eng_act[$];
    rsp_t        exp_rsp[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_grants = 0;
    int cyc      = 0;
    int last_start_cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void eg(input int r);
        exp_grant.push_back(r);
    endfunction
    function automatic void es(input logic [5:0] i, input logic [31:0] a);
        exp_start.push_back({i, a});
    endfunction
    function automatic void ea(input kind_e k, input int d, input logic [39:0] r);
        act_t a;
        a.kind = k; a.delay = d; a.resp = r;
        eng_act.push_back(a);
    endfunction
    function automatic void er(input int id, input logic [1:0] st, input logic [39:0] d);
        rsp_t e;
        e.id = id; e.st = st; e.data = d;
        exp_rsp.push_back(e);
    endfunction

    // Monitors: grants, engine starts, completions.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (|bus.req_ready_o) begin
                n_grants++;
                if (exp_grant.size() == 0) begin
                    check("grant_unexpected", 64'(bus.req_ready_o), 64'd0);
                end else begin
                    int g;
                    logic [NR-1:0] oh;
                    g = exp_grant.pop_front();
                    oh = '0;
                    oh[g] = 1'b1;
                    check("grant_onehot", 64'(bus.req_ready_o), 64'(oh));
                end
            end
            if (bus.eng_start_o) begin
                last_start_cyc = cyc;
                if (exp_start.size() == 0) begin
                    check("start_unexpected", 64'(bus.eng_start_o), 64'd0);
                end else begin
                    logic [37:0] s;
                    s = exp_start.pop_front();
                    check("start_index", 64'(bus.eng_index_o), 64'(s[37:32]));
                    check("start_arg", 64'(bus.eng_arg_o), 64'(s[31:0]));
                end
            end
            if (|bus.rsp_valid_o) begin
                if (exp_rsp.size() == 0) begin
                    check("rsp_unexpected", 64'(bus.rsp_valid_o), 64'd0);
                end else begin
                    rsp_t e;
                    logic [NR-1:0] oh;
                    e = exp_rsp.pop_front();
                    oh = '0;
                    oh[e.id] = 1'b1;
                    check("rsp_valid_id", 64'(bus.rsp_valid_o), 64'(oh));
                    check("rsp_status", 64'(bus.rsp_status_o), 64'(e.st));
                    check("rsp_data", 64'(bus.rsp_data_o), 64'(e.data));
                    if (e.st == 2'b11) check("wdog_latency", 64'(cyc - last_start_cyc), 64'(WD + 1));
                end
            end
        end
    end

    // Engine model: one scripted action per start; busy lingers a cycle after the event.
    initial begin
        bus.eng_busy_i      = 1'b0;
        bus.eng_done_i      = 1'b0;
        bus.eng_timeout_i   = 1'b0;
        bus.eng_crc_error_i = 1'b0;
        bus.eng_response_i  = 40'd0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.eng_start_o) begin
                act_t a;
                bit   ab;
                a.kind = KDone; a.delay = 0; a.resp = 40'd0;
                if (eng_act.size() != 0) a = eng_act.pop_front();
                bus.eng_busy_i = 1'b1;
                ab = 1'b0;
                for (int k = 0; k < a.delay; k++) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        ab = 1'b1;
                        break;
                    end
                end
                if (!ab && a.kind != KNone) begin
                    @(negedge clk);
                    if (rst_n) begin
                        bus.eng_response_i  = a.resp;
                        bus.eng_done_i      = (a.kind == KDone);
                        bus.eng_crc_error_i = (a.kind == KCrc);
                        bus.eng_timeout_i   = (a.kind == KTo);
                    end
                    @(negedge clk);
                    bus.eng_done_i      = 1'b0;
                    bus.eng_crc_error_i = 1'b0;
                    bus.eng_timeout_i   = 1'b0;
                end
                @(negedge clk);
                bus.eng_busy_i = 1'b0;
            end
        end
    end

    task automatic do_req(input int r, input logic app, input logic [5:0] idx,
                          input logic [31:0] arg);
        bit got;
        got = 1'b0;
        @(posedge clk);
        #1;
        bus.req_app_i[r]            = app;
        bus.req_index_i[6*r +: 6]   = idx;
        bus.req_arg_i[32*r +: 32]   = arg;
        bus.req_valid_i[r]          = 1'b1;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (rst_n && bus.req_ready_o[r]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("req_ready_timeout", 64'(got), 64'd1);
        @(posedge clk);
        #1;
        bus.req_valid_i[r] = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 2000; k++) begin
            if (exp_rsp.size() == 0 && exp_start.size() == 0 && exp_grant.size() == 0) break;
            @(negedge clk);
        end
        check("drain_pending", 64'(exp_rsp.size() + exp_start.size() + exp_grant.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req_ready"}, 64'(bus.req_ready_o), 64'd0);
        check({tag, "_rsp_valid"}, 64'(bus.rsp_valid_o), 64'd0);
        check({tag, "_status"}, 64'(bus.rsp_status_o), 64'd0);
        check({tag, "_data"}, 64'(bus.rsp_data_o), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_grant_id"}, 64'(gid), 64'd0);
        check({tag, "_retry"}, 64'(rcnt), 64'd0);
        check({tag, "_eng_start"}, 64'(bus.eng_start_o), 64'd0);
        check({tag, "_eng_index"}, 64'(bus.eng_index_o), 64'd0);
        check({tag, "_eng_arg"}, 64'(bus.eng_arg_o), 64'd0);
    endtask

    initial begin
        #500000;
        n_fail++;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int g0;
        bus.req_valid_i = '0;
        bus.req_app_i   = '0;
        bus.req_index_i = '0;
        bus.req_arg_i   = '0;
        rca = 16'h1234;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("por");
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        arb_en = 1'b1;

        // Single request, 20-cycle engine latency.
        eg(2); es(6'd17, 32'h200); ea(KDone, 19, 40'hAB_CDEF_0123); er(2, 2'b00, 40'hAB_CDEF_0123);
        do_req(2, 1'b0, 6'd17, 32'h200);
        drain();
        check("t1_busy_idle", 64'(busy), 64'd0);
        check("t1_grant_id", 64'(gid), 64'd2);

        // Round robin 0,1,2,0 with pointer wrap.
        eg(0); eg(1); eg(2); eg(0);
        es(6'd1, 32'h10); es(6'd2, 32'h20); es(6'd3, 32'h30); es(6'd4, 32'h40);
        ea(KDone, 0, 40'h11); ea(KDone, 0, 40'h22); ea(KDone, 0, 40'h33); ea(KDone, 0, 40'h44);
        er(0, 2'b00, 40'h11); er(1, 2'b00, 40'h22); er(2, 2'b00, 40'h33); er(0, 2'b00, 40'h44);
        fork
            begin
                do_req(0, 1'b0, 6'd1, 32'h10);
                do_req(0, 1'b0, 6'd4, 32'h40);
            end
            do_req(1, 1'b0, 6'd2, 32'h20);
            do_req(2, 1'b0, 6'd3, 32'h30);
        join
        drain();

        // ACMD41: CMD55 prefix with RCA argument, then the main command.
        eg(0); es(6'd55, 32'h1234_0000); es(6'd41, 32'h40FF_8000);
        ea(KDone, 2, 40'h37_0000_0120); ea(KDone, 3, 40'h3F_00FF_8000);
        er(0, 2'b00, 40'h3F_00FF_8000);
        do_req(0, 1'b1, 6'd41, 32'h40FF_8000);
        drain();
        check("acmd_index_held", 64'(bus.eng_index_o), 64'd41);
        check("acmd_arg_held", 64'(bus.eng_arg_o), 64'h40FF_8000);

        // CRC three times: retries exhausted, data keeps last success.
        eg(1); es(6'd17, 32'h400); es(6'd17, 32'h400); es(6'd17, 32'h400);
        ea(KCrc, 1, 40'h0); ea(KCrc, 1, 40'h0); ea(KCrc, 1, 40'h0);
        er(1, 2'b10, 40'h3F_00FF_8000);
        do_req(1, 1'b0, 6'd17, 32'h400);
        drain();
        check("crc_retry_cnt", 64'(rcnt), 64'd2);

        // CRC then done.
        eg(2); es(6'd18, 32'h800); es(6'd18, 32'h800);
        ea(KCrc, 0, 40'h0); ea(KDone, 1, 40'h12_3456_7890);
        er(2, 2'b00, 40'h12_3456_7890);
        do_req(2, 1'b0, 6'd18, 32'h800);
        drain();
        check("crc_then_ok_retry_cnt", 64'(rcnt), 64'd1);

        // Timeout: no reissue.
        eg(0); es(6'd24, 32'h1000); ea(KTo, 4, 40'h0); er(0, 2'b01, 40'h12_3456_7890);
        do_req(0, 1'b0, 6'd24, 32'h1000);
        drain();
        check("timeout_retry_cnt", 64'(rcnt), 64'd0);

        // Watchdog abort, then the pending requester is served.
        eg(1); eg(2); es(6'd25, 32'h2000); es(6'd7, 32'h3);
        ea(KNone, 10, 40'h0); ea(KDone, 0, 40'h00_DEAD_BEEF);
        er(1, 2'b11, 40'h12_3456_7890); er(2, 2'b00, 40'h00_DEAD_BEEF);
        fork
            do_req(1, 1'b0, 6'd25, 32'h2000);
            do_req(2, 1'b0, 6'd7, 32'h3);
        join
        drain();

        // Enable low blocks grants.
        eg(0); es(6'd9, 32'h9); ea(KDone, 1, 40'h99); er(0, 2'b00, 40'h99);
        @(posedge clk);
        #1;
        arb_en = 1'b0;
        g0 = n_grants;
        fork
            do_req(0, 1'b0, 6'd9, 32'h9);
            begin
                repeat (20) @(negedge clk);
                check("disabled_no_grant", 64'(n_grants - g0), 64'd0);
                check("disabled_busy", 64'(busy), 64'd0);
                @(posedge clk);
                #1;
                arb_en = 1'b1;
            end
        join
        drain();

        // Reset in WAIT: aborted request gives no response; re-grant starts from r0.
        eg(1); es(6'd12, 32'h12); ea(KNone, 500, 40'h0);
        do_req(1, 1'b0, 6'd12, 32'h12);
        for (int k = 0; k < 100; k++) begin
            if (exp_start.size() == 0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("wait_busy", 64'(busy), 64'd1);
        check("wait_grant_id", 64'(gid), 64'd1);
        eg(0); eg(2); es(6'd13, 32'h13); es(6'd14, 32'h14);
        ea(KDone, 0, 40'hA1); ea(KDone, 0, 40'hA2);
        er(0, 2'b00, 40'hA1); er(2, 2'b00, 40'hA2);
        fork
            do_req(0, 1'b0, 6'd13, 32'h13);
            do_req(2, 1'b0, 6'd14, 32'h14);
            begin
                @(posedge clk);
                #1;
                rst_n = 1'b0;
                @(negedge clk);
                check_reset("midrst");
                repeat (3) @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
        join
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
